// File: rtl/stream_qpp_interleaver_pkg.sv
// Shared types and constant helpers for the QPP stream interleaver.
package stream_qpp_interleaver_pkg;

   // Direction of the permutation applied to each block.
   typedef enum logic {
      QPP_INTERLEAVE   = 1'b0,
      QPP_DEINTERLEAVE = 1'b1
   } qpp_mode_t;

   // Reader FSM: waiting for a full bank, or streaming one block out.
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BUSY = 1'b1
   } rd_state_t;

   // Per-step increment of the first difference g: 2*F2 mod N.
   function automatic int qpp_step_const(input int n, input int f2);
      return (2 * f2) % n;
   endfunction

   // Initial first difference g(0) = (F1 + F2) mod N.
   function automatic int qpp_g0(input int n, input int f1, input int f2);
      return (f1 + f2) % n;
   endfunction

endpackage

// File: rtl/stream_qpp_interleaver_if.sv
// LLR stream bundle between a producer and the interleaver.
// Handshake: valid-only, no ready. A symbol is transferred on every rising
// clk edge where in_valid (or out_valid) is high; the receiver must always
// accept it. rd_state exposes the reader FSM for observation.
interface stream_qpp_interleaver_if
   import stream_qpp_interleaver_pkg::*;
#(
   parameter int BITS            = 16,
   parameter int BITS_PER_SYMBOL = 2
);
   logic                                  in_valid;
   logic [BITS_PER_SYMBOL-1:0][BITS-1:0]  LLR_in;
   logic                                  out_valid;
   logic                                  out_block_start;
   logic [BITS_PER_SYMBOL-1:0][BITS-1:0]  LLR_out;
   rd_state_t                             rd_state;

   modport master (
      output in_valid, LLR_in,
      input  out_valid, out_block_start, LLR_out, rd_state
   );

   modport slave (
      input  in_valid, LLR_in,
      output out_valid, out_block_start, LLR_out, rd_state
   );
endinterface

// File: rtl/stream_qpp_interleaver_qpp_address_gen.sv
// Incremental QPP address generator: pi(i) = (F1*i + F2*i^2) mod N using
// only adders and one conditional subtract per modular add.
module qpp_address_gen
   import stream_qpp_interleaver_pkg::*;
#(
   parameter int N  = 40,
   parameter int F1 = 3,
   parameter int F2 = 10,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          restart,
   input  logic          advance,
   output logic [AW-1:0] addr
);
   localparam logic [AW:0]   N_W  = (AW+1)'(N);
   localparam logic [AW-1:0] G0   = AW'(qpp_g0(N, F1, F2));
   localparam logic [AW-1:0] STEP = AW'(qpp_step_const(N, F2));

   logic [AW-1:0] pi_q;
   logic [AW-1:0] g_q;

   // (a + b) mod N for operands already below N.
   function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
      logic [AW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= N_W) s = s - N_W;
      return s[AW-1:0];
   endfunction

   // restart wins over advance so the last step of a block rewinds to pi(0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pi_q <= '0;
         g_q  <= G0;
      end else if (restart) begin
         pi_q <= '0;
         g_q  <= G0;
      end else if (advance) begin
         pi_q <= mod_add(pi_q, g_q);
         g_q  <= mod_add(g_q, STEP);
      end
   end

   assign addr = pi_q;
endmodule

// File: rtl/stream_qpp_interleaver.sv
// Ping-pong block interleaver for the turbo loop: blocks are written in
// standard order into one bank and read back permuted from the other.
module stream_qpp_interleaver
   import stream_qpp_interleaver_pkg::*;
#(
   parameter int BITS            = 16,
   parameter int BITS_PER_SYMBOL = 2,
   parameter int SYMBOLS         = 40,
   parameter int F1              = 3,
   parameter int F2              = 10,
   parameter int MODE            = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   stream_qpp_interleaver_if.slave   io
);
   localparam int            W        = BITS * BITS_PER_SYMBOL;
   localparam int            AW       = $clog2(SYMBOLS);
   localparam logic [AW-1:0] LAST     = AW'(SYMBOLS - 1);
   localparam logic [AW:0]   N_W      = (AW+1)'(SYMBOLS);
   localparam bit            IS_DEINT = (MODE == int'(QPP_DEINTERLEAVE));

   // Writer side
   logic [AW-1:0] wi_q;
   logic          wb_q;
   logic          wr_last;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   wr_idx;

   // Reader side
   rd_state_t     state_q, state_d;
   logic [AW-1:0] ri_q;
   logic          rb_q;
   logic          rd_en;
   logic          rd_last;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   rd_idx;

   logic [1:0]    full_q;
   logic [W-1:0]  mem [0:2*SYMBOLS-1];

   assign wr_last = io.in_valid && (wi_q == LAST);

   // The permutation generator sits on whichever side is not sequential.
   generate
      if (IS_DEINT) begin : g_deint
         qpp_address_gen #(.N(SYMBOLS), .F1(F1), .F2(F2), .AW(AW)) u_gen (
            .clk(clk), .rst(rst), .restart(wr_last), .advance(io.in_valid), .addr(wr_addr)
         );
         assign rd_addr = ri_q;
      end else begin : g_int
         qpp_address_gen #(.N(SYMBOLS), .F1(F1), .F2(F2), .AW(AW)) u_gen (
            .clk(clk), .rst(rst), .restart(rd_last), .advance(rd_en), .addr(rd_addr)
         );
         assign wr_addr = wi_q;
      end
   endgenerate

   assign wr_idx = wb_q ? (N_W + {1'b0, wr_addr}) : {1'b0, wr_addr};
   assign rd_idx = rb_q ? (N_W + {1'b0, rd_addr}) : {1'b0, rd_addr};

   // Write counter and bank toggle; wi only moves on accepted symbols.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wi_q <= '0;
         wb_q <= 1'b0;
      end else if (io.in_valid) begin
         wi_q <= wr_last ? '0 : wi_q + 1'b1;
         if (wr_last) wb_q <= ~wb_q;
      end
   end

   // Reader next state: an idle reader issues ri=0 in the same cycle it sees
   // a full bank, so finishing one bank and starting the next has no bubble.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (full_q[rb_q]) begin
               rd_en   = 1'b1;
               state_d = RD_BUSY;
            end
         end
         RD_BUSY: rd_en = 1'b1;
         default: state_d = RD_IDLE;
      endcase
      rd_last = rd_en && (ri_q == LAST);
      if (rd_last) state_d = RD_IDLE;
   end

   // Reader state, read counter and read bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RD_IDLE;
         ri_q    <= '0;
         rb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rd_en) ri_q <= rd_last ? '0 : ri_q + 1'b1;
         if (rd_last) rb_q <= ~rb_q;
      end
   end

   // Bank occupancy: writer marks full, reader releases after its last read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 2'b00;
      end else begin
         if (rd_last) full_q[rb_q] <= 1'b0;
         if (wr_last) full_q[wb_q] <= 1'b1;
      end
   end

   // Ping-pong storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (io.in_valid) mem[wr_idx] <= io.LLR_in;
   end

   // Registered output: synchronous RAM read lands directly in LLR_out,
   // which holds its last value while no read is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io.out_valid       <= 1'b0;
         io.out_block_start <= 1'b0;
         io.LLR_out         <= '0;
      end else begin
         io.out_valid       <= rd_en;
         io.out_block_start <= rd_en && (ri_q == '0);
         if (rd_en) io.LLR_out <= mem[rd_idx];
      end
   end

   assign io.rd_state = state_q;
endmodule

// File: tb/tb_stream_qpp_interleaver.sv
// Scoreboard bench for stream_qpp_interleaver: N=10 interleave/deinterleave
// pair, an interleave->deinterleave chain, and the LTE K=40 configuration.
module tb_stream_qpp_interleaver;
   import stream_qpp_interleaver_pkg::*;

   localparam int EW = 49;  // {cycle[15:0], block_start, data[31:0]}

   logic clk = 1'b0;
   logic rst_ab;
   logic rst_x;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic        s_v;
   logic [31:0] s_d;
   int          sel;

   logic [EW-1:0] qa[$];
   logic [EW-1:0] qb[$];
   logic [EW-1:0] qc[$];
   logic [EW-1:0] q40[$];
   int            seen40[40];

   int pi10[10]  = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7};
   int dil10[10] = '{0, 7, 4, 1, 8, 5, 2, 9, 6, 3};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   stream_qpp_interleaver_if #(.BITS(16), .BITS_PER_SYMBOL(2)) ifa ();
   stream_qpp_interleaver_if #(.BITS(16), .BITS_PER_SYMBOL(2)) ifb ();
   stream_qpp_interleaver_if #(.BITS(16), .BITS_PER_SYMBOL(2)) ifc0 ();
   stream_qpp_interleaver_if #(.BITS(16), .BITS_PER_SYMBOL(2)) ifc1 ();
   stream_qpp_interleaver_if #(.BITS(16), .BITS_PER_SYMBOL(2)) ifd ();

   assign ifa.in_valid  = s_v && (sel == 0);
   assign ifa.LLR_in    = s_d;
   assign ifb.in_valid  = s_v && (sel == 0);
   assign ifb.LLR_in    = s_d;
   assign ifc0.in_valid = s_v && (sel == 1);
   assign ifc0.LLR_in   = s_d;
   assign ifc1.in_valid = ifc0.out_valid;
   assign ifc1.LLR_in   = ifc0.LLR_out;
   assign ifd.in_valid  = s_v && (sel == 2);
   assign ifd.LLR_in    = s_d;

   stream_qpp_interleaver #(.BITS(16), .BITS_PER_SYMBOL(2), .SYMBOLS(10), .F1(3), .F2(0), .MODE(0))
      u_a (.clk(clk), .rst(rst_ab), .io(ifa));
   stream_qpp_interleaver #(.BITS(16), .BITS_PER_SYMBOL(2), .SYMBOLS(10), .F1(3), .F2(0), .MODE(1))
      u_b (.clk(clk), .rst(rst_ab), .io(ifb));
   stream_qpp_interleaver #(.BITS(16), .BITS_PER_SYMBOL(2), .SYMBOLS(10), .F1(3), .F2(0), .MODE(0))
      u_c0 (.clk(clk), .rst(rst_x), .io(ifc0));
   stream_qpp_interleaver #(.BITS(16), .BITS_PER_SYMBOL(2), .SYMBOLS(10), .F1(3), .F2(0), .MODE(1))
      u_c1 (.clk(clk), .rst(rst_x), .io(ifc1));
   stream_qpp_interleaver #(.BITS(16), .BITS_PER_SYMBOL(2), .SYMBOLS(40), .F1(3), .F2(10), .MODE(0))
      u_d (.clk(clk), .rst(rst_x), .io(ifd));

   // ---------------- scoreboard helpers ----------------
   function automatic logic [EW-1:0] pack_exp(input int c, input logic s, input logic [31:0] d);
      return {16'(c), s, d};
   endfunction

   task automatic chk_out(input string nm, input logic [EW-1:0] e, input logic s, input logic [31:0] d);
      n_chk++;
      if ({16'(cyc), s, d} !== e) begin
         n_fail++;
         $display("FAIL %s: got cyc=%0d start=%0b data=%h, expected cyc=%0d start=%0b data=%h",
                  nm, cyc[15:0], s, d, e[48:33], e[32], e[31:0]);
      end
   endtask

   task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic extra(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s_extra: got unexpected out_valid at cyc=%0d, expected no output", nm, cyc);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (ifa.out_valid) begin
         if (qa.size() == 0) extra("A");
         else chk_out("A_out", qa.pop_front(), ifa.out_block_start, ifa.LLR_out);
      end
      if (ifb.out_valid) begin
         if (qb.size() == 0) extra("B");
         else chk_out("B_out", qb.pop_front(), ifb.out_block_start, ifb.LLR_out);
      end
      if (ifc1.out_valid) begin
         if (qc.size() == 0) extra("CHAIN");
         else chk_out("CHAIN_out", qc.pop_front(), ifc1.out_block_start, ifc1.LLR_out);
      end
      if (ifd.out_valid) begin
         if (ifd.LLR_out[0] < 16'd40) seen40[int'(ifd.LLR_out[0])]++;
         if (q40.size() == 0) extra("K40");
         else chk_out("K40_out", q40.pop_front(), ifd.out_block_start, ifd.LLR_out);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic put(input logic v, input logic [31:0] d, output int t);
      @(posedge clk);
      #1;
      s_v = v;
      s_d = d;
      t   = cyc;
   endtask

   task automatic idle(input int n);
      int t;
      repeat (n) put(1'b0, '0, t);
   endtask

   // One N=10 block to the A/B pair; lane 0 carries base+i, lane 1 a tag.
   task automatic send_ab(input int base, input bit gaps);
      logic [31:0] blk[10];
      int t;
      for (int i = 0; i < 10; i++) begin
         if (gaps) while ($urandom_range(0, 1) == 1) put(1'b0, '0, t);
         blk[i] = {16'hA000 + 16'(base + i), 16'(base + i)};
         put(1'b1, blk[i], t);
      end
      for (int k = 0; k < 10; k++) begin
         qa.push_back(pack_exp(t + 2 + k, k == 0, blk[pi10[k]]));
         qb.push_back(pack_exp(t + 2 + k, k == 0, blk[dil10[k]]));
      end
   endtask

   // Interleave then deinterleave must return the block unchanged.
   task automatic send_chain(input int nblk);
      logic [31:0] blk[10];
      int t;
      for (int b = 0; b < nblk; b++) begin
         for (int i = 0; i < 10; i++) begin
            blk[i] = $urandom;
            put(1'b1, blk[i], t);
         end
         for (int k = 0; k < 10; k++)
            qc.push_back(pack_exp(t + 13 + k, k == 0, blk[k]));
      end
   endtask

   // LTE K=40 block checked against the closed-form permutation.
   task automatic send_k40();
      logic [31:0] blk[40];
      int t;
      for (int i = 0; i < 40; i++) begin
         blk[i] = {16'($urandom), 16'(i)};
         put(1'b1, blk[i], t);
      end
      for (int k = 0; k < 40; k++)
         q40.push_back(pack_exp(t + 2 + k, k == 0, blk[(3 * k + 10 * k * k) % 40]));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t;
      s_v    = 1'b0;
      s_d    = '0;
      sel    = 0;
      rst_ab = 1'b1;
      rst_x  = 1'b1;
      for (int i = 0; i < 40; i++) seen40[i] = 0;

      repeat (3) @(posedge clk);
      #1;
      chk_val("A_rst_valid", 32'(ifa.out_valid), 32'd0);
      chk_val("A_rst_start", 32'(ifa.out_block_start), 32'd0);
      chk_val("A_rst_data", ifa.LLR_out, 32'd0);
      chk_val("A_rst_state", 32'(ifa.rd_state), 32'(RD_IDLE));
      chk_val("B_rst_valid", 32'(ifb.out_valid), 32'd0);
      chk_val("K40_rst_data", ifd.LLR_out, 32'd0);
      rst_ab = 1'b0;
      rst_x  = 1'b0;
      idle(2);

      // Single contiguous block, interleave and deinterleave side by side.
      send_ab(0, 1'b0);
      idle(15);

      // Three blocks with random input gaps.
      send_ab(16, 1'b1);
      send_ab(32, 1'b1);
      send_ab(48, 1'b1);
      idle(15);

      // Reset in the middle of block 2 while block 1 drains.
      send_ab(100, 1'b0);
      for (int i = 0; i < 5; i++) put(1'b1, {16'hB000, 16'(200 + i)}, t);
      @(posedge clk);
      #1;
      s_v    = 1'b0;
      rst_ab = 1'b1;
      qa.delete();
      qb.delete();
      @(posedge clk);
      #1;
      chk_val("A_valid_after_rst", 32'(ifa.out_valid), 32'd0);
      chk_val("B_valid_after_rst", 32'(ifb.out_valid), 32'd0);
      rst_ab = 1'b0;
      idle(2);
      send_ab(0, 1'b0);
      idle(15);

      // Chained interleave -> deinterleave, four back-to-back blocks.
      sel = 1;
      send_chain(4);
      idle(2);

      // LTE K=40.
      sel = 2;
      send_k40();
      idle(2);

      for (int i = 0; i < 400 && (qa.size() + qb.size() + qc.size() + q40.size()) > 0; i++)
         @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      chk_val("A_pending", qa.size(), 32'd0);
      chk_val("B_pending", qb.size(), 32'd0);
      chk_val("CHAIN_pending", qc.size(), 32'd0);
      chk_val("K40_pending", q40.size(), 32'd0);
      for (int i = 0; i < 40; i++) chk_val($sformatf("K40_perm_%0d", i), seen40[i], 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
